// File: rtl/minc_trace.sv
// rtl/minc_trace.sv - execution-trace capture buffer with halt/timeout stop and show-ahead readout
// Optional: define MINC_TRACE_WRAP_EN for a circular buffer (keeps the last DEPTH samples).
module minc_trace #(
  parameter int W           = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 256,
  parameter int HALT_CYCLES = 4
) (
  input  logic                     CLK,
  input  logic                     nRESET,
  input  logic [W-1:0]             pc_in,
  input  logic [W-1:0]             top_in,
  input  logic [W-1:0]             sp_in,
  input  logic                     arm,
  input  logic                     rd_en,
  output logic [3*W-1:0]           rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     halted,
  output logic                     timeout,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [SW-1:0]   sc_q, sc_d;
  logic [W-1:0]    prev_pc_q, prev_pc_d;
  logic            halted_q, halted_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic            we;
  logic [3*W-1:0]  mem [DEPTH];

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      sc_q       <= '0;
      prev_pc_q  <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      sc_q       <= sc_d;
      prev_pc_q  <= prev_pc_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  // Trace RAM is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (we) mem[wr_ptr_q] <= {pc_in, top_in, sp_in};
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cyc_d      = cyc_q;
    sc_d       = sc_q;
    prev_pc_d  = prev_pc_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d    = CAPTURE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          cyc_d      = '0;
          sc_d       = '0;
          halted_d   = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
        end else if (state_q == DONE && rd_en && count_q != '0) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - (AW+1)'(1);
        end
      end
      CAPTURE: begin
        // The first capture cycle has no previous PC to compare against.
        sc_d      = (cyc_q != '0 && pc_in == prev_pc_q) ? sc_q + SW'(1) : '0;
        prev_pc_d = pc_in;
        cyc_d     = cyc_q + CW'(1);
        if (count_q == (AW+1)'(DEPTH)) begin
          overflow_d = 1'b1;
`ifdef MINC_TRACE_WRAP_EN
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          rd_ptr_d = rd_ptr_q + AW'(1);
`else
          we       = 1'b0;
`endif
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + (AW+1)'(1);
        end
        if (sc_d == SW'(HALT_CYCLES)) halted_d = 1'b1;
        if (cyc_q == CW'(TIMEOUT - 1)) timeout_d = 1'b1;
        if (sc_d == SW'(HALT_CYCLES) || cyc_q == CW'(TIMEOUT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_valid = (state_q == DONE) && (count_q != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
  assign state    = state_q;
  assign halted   = halted_q;
  assign timeout  = timeout_q;
  assign overflow = overflow_q;
endmodule

// File: doc/minc_trace.md
# minc_trace

Parametrised execution-trace capture unit for the minc core. It samples the core's `pc_out`/`top_out`/`sp_out` every clock into an on-chip buffer and stops on a halt condition (PC stalled) or a cycle timeout. Captured samples are then read out through a show-ahead pop interface. It sits beside `minc` at the top level, so trace and run-limit checks work in silicon, not just in simulation.

## Interface
Parameters:
- `W`, 8: width of each traced field (PC, TOP, SP).
- `DEPTH`, 16: buffer entries; power of two, ≥2.
- `TIMEOUT`, 256: maximum capture cycles, ≥1.
- `HALT_CYCLES`, 4: consecutive unchanged-PC cycles that declare a halt, ≥1.

Ports:
- `CLK` in 1: single clock, rising edge.
- `nRESET` in 1: reset, asynchronous, active-low.
- `pc_in` in W: core PC.
- `top_in` in W: core stack top.
- `sp_in` in W: core stack pointer.
- `arm` in 1: start or restart capture.
- `rd_en` in 1: pop the oldest sample.
- `rd_data` out 3W: oldest sample `{pc, top, sp}`; 0 when `rd_valid`=0.
- `rd_valid` out 1: readout sample available.
- `count` out log2(DEPTH)+1: number of stored samples.
- `state` out 2: 0=IDLE, 1=CAPTURE, 2=DONE.
- `halted` out 1: capture ended on PC stall.
- `timeout` out 1: capture ended on TIMEOUT.
- `overflow` out 1: at least one sample lost or overwritten.

## Operation
- Reset: `state`=IDLE. `count`, pointers, cycle counter, stall counter, `halted`, `timeout` and `overflow` are all 0. `rd_valid`=0 and `rd_data`=0. Buffer RAM is not reset.
- IDLE: waits for `arm`=1, then moves to CAPTURE. `rd_en` is ignored.
- CAPTURE: writes `{pc_in, top_in, sp_in}` every cycle.
  - Cycle counter `cyc` starts at 0 and increments per capture cycle.
  - Stall counter `sc` increments when `pc_in` equals the previous cycle's `pc_in`. Otherwise it is cleared. On the first capture cycle there is no previous PC, so `sc`=0.
  - Stop when `sc` reaches HALT_CYCLES or `cyc`=TIMEOUT-1. The current sample is still written, the matching flag(s) set, and the next state is DONE. If both conditions hit in the same cycle, both flags are set.
  - `arm` and `rd_en` are ignored.
- Buffer full (`count`=DEPTH) on a write: behaviour is set by the configuration (see below). In both modes `overflow` is set to 1.
- DONE: readout only.
  - `rd_valid`=(`count`≠0).
  - `rd_data` shows the oldest entry combinationally (show-ahead).
  - `rd_en`&&`rd_valid`: advance the read pointer and decrement `count`.
  - `rd_en` while empty: no effect.
- `arm` in DONE: clears the buffer, counters and all flags, and enters CAPTURE next cycle. It takes priority over `rd_en` in that cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `cyc` is wide enough to hold TIMEOUT-1.

## Timing
- `arm` high at edge n: `state`=CAPTURE after edge n. The first sample is written at edge n+1.
- Maximum capture length is exactly TIMEOUT samples-cycles. `state`=DONE after the final write edge.
- `halted`, `timeout`, `overflow` and `count` are registered. They update on the same edge as the write or pop that causes them.
- `rd_data` and `rd_valid` are combinational from the registered pointers and `count`. Pop-to-next-data takes one edge.
- `nRESET` low at any time, including mid-capture or mid-readout, forces the reset values immediately, without waiting for a clock edge. Operation resumes in IDLE.

## Configuration
- `MINC_TRACE_WRAP_EN` defined: the buffer is circular. A write when full overwrites the oldest entry and advances the read pointer. `count` stays DEPTH, so the buffer holds the last DEPTH samples before the stop.
- `MINC_TRACE_WRAP_EN` undefined: a write when full is dropped. Capture, halt detection and timeout continue. The buffer holds the first DEPTH samples.

## Test plan
All scenarios use defaults W=8, DEPTH=16, TIMEOUT=256, HALT_CYCLES=4.
- Reset: hold `nRESET`=0 for 2 cycles -> `state`=0, `count`=0, `rd_valid`=0, `rd_data`=0, all flags 0.
- Halt: pulse `arm`, then drive pc 0x00,0x01,…,0x05 followed by five more 0x05 (10 samples) -> `halted`=1, `timeout`=0, `overflow`=0, `count`=10, `state`=2, first `rd_data` pc=0x00.
- Readout: from the halt case, assert `rd_en` for 12 cycles -> pc values 0x00..0x05, 0x05×4 in order. `rd_valid` drops after the 10th pop. `count`=0. The extra pops have no effect.
- Timeout: pulse `arm`, increment pc by 1 from 0x00 every cycle -> after 256 capture cycles `timeout`=1, `overflow`=1, `count`=16.
  - Without the macro: first pop gives pc=0x00.
  - With `MINC_TRACE_WRAP_EN`: first pop gives pc=0xF0, last pop gives pc=0xFF.
- Reset mid-capture: pulse `nRESET` low 5 cycles after `arm` -> `state`=0, `count`=0 and flags 0 immediately, without waiting for a clock edge.
- Re-arm: after the halt scenario, pulse `arm` in DONE -> `halted`=0, `count`=0, `state`=1 next cycle. A new capture with a constant pc=0x20 halts with `count`=5.
